// File: rtl/lut_neuron_pkg.sv
// rtl/lut_neuron_pkg.sv - shared types and helpers for the reloadable LUT neuron
// Contents: state_t controller states, depth() table depth for a given address width.
package lut_neuron_pkg;

   typedef enum logic [1:0] {
      UNLOADED = 2'd0,
      LOADING  = 2'd1,
      RUN      = 2'd2,
      DRAIN    = 2'd3
   } state_t;

   function automatic int depth(input int in_bits);
      return 1 << in_bits;
   endfunction

endpackage

// File: rtl/lut_neuron_stream_if.sv
// rtl/lut_neuron_stream_if.sv - config, input and output handshake bundle of the LUT neuron
// Ports: cfg_start/cfg_valid/cfg_data -> neuron, cfg_ready/cfg_done/loaded <- neuron,
//        in_valid/in_data -> neuron, in_ready <- neuron, out_valid/out_data <- neuron, out_ready -> neuron.
interface lut_neuron_stream_if #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1
);
   logic                cfg_start;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [OUT_BITS-1:0] cfg_data;
   logic                cfg_done;
   logic                loaded;
   logic                in_valid;
   logic                in_ready;
   logic [IN_BITS-1:0]  in_data;
   logic                out_valid;
   logic                out_ready;
   logic [OUT_BITS-1:0] out_data;

   modport master (
      output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
      input  cfg_ready, cfg_done, loaded, in_ready, out_valid, out_data
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
      output cfg_ready, cfg_done, loaded, in_ready, out_valid, out_data
   );
endinterface

// File: rtl/lut_dist_ram.sv
// rtl/lut_dist_ram.sv - truth-table storage, one synchronous write port and one asynchronous read port
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module lut_dist_ram
   import lut_neuron_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // Contents are deliberately not reset; a fresh load is always required after reset.
   (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [0:depth(ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_stream.sv
// rtl/lut_neuron_stream.sv - reloadable truth-table neuron with a 2-stage valid/ready inference pipeline
// Ports: clk; rst synchronous active-high; bus (slave) carries config load stream,
//        input words (table addresses) and output results (table entries).
module lut_neuron_stream
   import lut_neuron_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1
) (
   input  logic               clk,
   input  logic               rst,
   lut_neuron_stream_if.slave bus
);

   state_t              state, state_n;
   logic [IN_BITS-1:0]  addr, addr_n;
   logic                done_q, done_n;

   logic                va, vb;
   logic [IN_BITS-1:0]  da;
   logic [OUT_BITS-1:0] db;
   logic [OUT_BITS-1:0] rd;

   logic                adva, advb;
   logic                in_fire;
   logic                beat;
   logic                last_beat;

   // Stage B frees when empty or drained downstream; stage A frees when it can move into B.
   assign advb    = !vb || bus.out_ready;
   assign adva    = !va || advb;
   assign in_fire = bus.in_valid && bus.in_ready;

   assign beat      = (state == LOADING) && bus.cfg_valid;
   assign last_beat = beat && (addr == IN_BITS'(depth(IN_BITS) - 1));

   assign bus.in_ready  = (state == RUN) && adva;
   assign bus.cfg_ready = (state == LOADING);
   assign bus.loaded    = (state == RUN) || (state == DRAIN);
   assign bus.cfg_done  = done_q;
   assign bus.out_valid = vb;
   assign bus.out_data  = db;

   always_comb begin
      state_n = state;
      addr_n  = addr;
      done_n  = 1'b0;
      case (state)
         UNLOADED: begin
            addr_n = '0;
            if (bus.cfg_start) begin
               state_n = LOADING;
            end
         end
         LOADING: begin
            if (bus.cfg_start) begin
               addr_n = '0;
            end else if (last_beat) begin
               state_n = RUN;
               addr_n  = '0;
               done_n  = 1'b1;
            end else if (beat) begin
               addr_n = addr + 1'b1;
            end
         end
         RUN: begin
            // A word accepted in this same cycle also counts as in flight, so it
            // never reads the table while the new contents are being written.
            if (bus.cfg_start) begin
               addr_n  = '0;
               state_n = (va || vb || in_fire) ? DRAIN : LOADING;
            end
         end
         DRAIN: begin
            if (!va && !vb) begin
               state_n = LOADING;
            end
         end
         default: begin
            state_n = UNLOADED;
            addr_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= UNLOADED;
         addr   <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         addr   <= addr_n;
         done_q <= done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         va <= 1'b0;
         vb <= 1'b0;
         da <= '0;
         db <= '0;
      end else begin
         if (adva) begin
            va <= in_fire;
            if (in_fire) begin
               da <= bus.in_data;
            end
         end
         if (advb) begin
            vb <= va;
            if (va) begin
               db <= rd;
            end
         end
      end
   end

   lut_dist_ram #(
      .ADDR_W (IN_BITS),
      .DATA_W (OUT_BITS)
   ) u_ram (
      .clk   (clk),
      .we    (beat),
      .waddr (addr),
      .wdata (bus.cfg_data),
      .raddr (da),
      .rdata (rd)
   );

endmodule

// File: tb/tb_lut_neuron_stream.sv
// tb/tb_lut_neuron_stream.sv - self-checking bench for lut_neuron_stream (8/1 and 4/3 instances)
module tb_lut_neuron_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lut_neuron_stream_if #(.IN_BITS(8), .OUT_BITS(1)) b8 ();
   lut_neuron_stream_if #(.IN_BITS(4), .OUT_BITS(3)) b4 ();

   lut_neuron_stream #(.IN_BITS(8), .OUT_BITS(1)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   lut_neuron_stream #(.IN_BITS(4), .OUT_BITS(3)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   int n_checks = 0;
   int n_fail   = 0;

   // Model: table contents as last loaded; each accepted word's result is fixed at acceptance.
   logic [2:0] mt8 [256];
   logic [2:0] mt4 [16];
   logic [2:0] new_tbl [256];
   logic [2:0] q8 [$];
   logic [2:0] q4 [$];
   logic       hold8 = 1'b0, hold4 = 1'b0;
   logic [2:0] held8, held4;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q8.delete();
         hold8 = 1'b0;
      end else begin
         if (hold8) begin
            chk("hold_valid8", b8.out_valid, 1);
            chk("hold_data8", b8.out_data, held8);
         end
         if (b8.out_valid) chk("out_expected8", q8.size() > 0, 1);
         if (b8.out_valid && b8.out_ready && q8.size() > 0) chk("out_data8", b8.out_data, q8.pop_front());
         hold8 = b8.out_valid && !b8.out_ready;
         held8 = 3'(b8.out_data);
         if (b8.in_valid && b8.in_ready) q8.push_back(mt8[b8.in_data]);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q4.delete();
         hold4 = 1'b0;
      end else begin
         if (hold4) begin
            chk("hold_valid4", b4.out_valid, 1);
            chk("hold_data4", b4.out_data, held4);
         end
         if (b4.out_valid) chk("out_expected4", q4.size() > 0, 1);
         if (b4.out_valid && b4.out_ready && q4.size() > 0) chk("out_data4", b4.out_data, q4.pop_front());
         hold4 = b4.out_valid && !b4.out_ready;
         held4 = b4.out_data;
         if (b4.in_valid && b4.in_ready) q4.push_back(mt4[b4.in_data]);
      end
   end

   function automatic logic f_cfg_ready(input int w);
      return (w == 8) ? b8.cfg_ready : b4.cfg_ready;
   endfunction
   function automatic logic f_cfg_done(input int w);
      return (w == 8) ? b8.cfg_done : b4.cfg_done;
   endfunction
   function automatic logic f_loaded(input int w);
      return (w == 8) ? b8.loaded : b4.loaded;
   endfunction
   function automatic logic f_in_ready(input int w);
      return (w == 8) ? b8.in_ready : b4.in_ready;
   endfunction
   function automatic int f_qsize(input int w);
      return (w == 8) ? q8.size() : q4.size();
   endfunction

   task automatic set_cfg(input int w, input logic v, input logic [2:0] d);
      if (w == 8) begin b8.cfg_valid = v; b8.cfg_data = d[0]; end
      else begin b4.cfg_valid = v; b4.cfg_data = d; end
   endtask

   task automatic set_in(input int w, input logic v, input logic [7:0] d);
      if (w == 8) begin b8.in_valid = v; b8.in_data = d; end
      else begin b4.in_valid = v; b4.in_data = d[3:0]; end
   endtask

   task automatic set_ordy(input int w, input logic r);
      if (w == 8) b8.out_ready = r; else b4.out_ready = r;
   endtask

   // Loads new_tbl; optionally pulses cfg_start, gaps every 3rd cycle, or resets after abort_at beats.
   task automatic load(input int w, input bit start, input bit gap, input int abort_at);
      int n, k, c, dcount;
      logic v;
      n = (w == 8) ? 256 : 16;
      for (int i = 0; i < n; i++) begin
         if (w == 8) mt8[i] = new_tbl[i]; else mt4[i] = new_tbl[i];
      end
      if (start) begin
         if (w == 8) b8.cfg_start = 1'b1; else b4.cfg_start = 1'b1;
         cyc();
         if (w == 8) b8.cfg_start = 1'b0; else b4.cfg_start = 1'b0;
      end
      k = 0; c = 0; dcount = 0;
      while (k < n && c < 3000) begin
         v = !(gap && (c % 3 == 2));
         set_cfg(w, v, new_tbl[k]);
         @(negedge clk);
         if (f_cfg_done(w)) dcount++;
         if (w == 8 && k == 128 && v) chk("loaded_mid_load", f_loaded(w), 0);
         if (v && f_cfg_ready(w)) k++;
         cyc();
         c++;
         if (k == abort_at) begin
            set_cfg(w, 1'b1, 3'd0);
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            @(negedge clk);
            chk("abort_loaded", f_loaded(w), 0);
            chk("abort_cfg_ready", f_cfg_ready(w), 0);
            cyc();
            set_cfg(w, 1'b0, 3'd0);
            return;
         end
      end
      set_cfg(w, 1'b0, 3'd0);
      chk("load_beats", k, n);
      chk("cfg_done_early", dcount, 0);
      @(negedge clk);
      chk("cfg_done_pulse", f_cfg_done(w), 1);
      chk("loaded_after_load", f_loaded(w), 1);
      cyc();
      @(negedge clk);
      chk("cfg_done_once", f_cfg_done(w), 0);
      cyc();
   endtask

   task automatic send(input int w, input logic [7:0] d);
      int t;
      t = 0;
      set_in(w, 1'b1, d);
      forever begin
         @(negedge clk);
         if (f_in_ready(w)) break;
         t++;
         if (t > 200) begin chk("send_timeout", t, 0); break; end
         cyc();
      end
      cyc();
   endtask

   task automatic expect_out(input int w, input string name, input logic [2:0] exp);
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if ((w == 8) ? b8.out_valid : b4.out_valid) break;
         t++;
         if (t > 50) break;
         cyc();
      end
      chk({name, "_valid"}, (w == 8) ? b8.out_valid : b4.out_valid, 1);
      chk(name, (w == 8) ? 3'(b8.out_data) : b4.out_data, exp);
      cyc();
   endtask

   // Every address once in random order, random input gaps and random output backpressure.
   task automatic sweep(input int w);
      int order [$];
      int n, idx, c, j, tmp;
      logic iv;
      n = (w == 8) ? 256 : 16;
      for (int i = 0; i < n; i++) order.push_back(i);
      for (int i = n - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      idx = 0; c = 0;
      while ((idx < n || f_qsize(w) > 0) && c < 5000) begin
         set_ordy(w, $urandom_range(0, 3) != 0);
         iv = (idx < n) && ($urandom_range(0, 3) != 0);
         set_in(w, iv, (idx < n) ? 8'(order[idx]) : 8'h00);
         @(negedge clk);
         if (iv && f_in_ready(w)) idx++;
         cyc();
         c++;
      end
      set_in(w, 1'b0, 8'h00);
      set_ordy(w, 1'b1);
      chk("sweep_sent", idx, n);
      chk("sweep_drained", f_qsize(w), 0);
   endtask

   initial begin
      b8.cfg_start = 0; b8.cfg_valid = 0; b8.cfg_data = 0; b8.in_valid = 0; b8.in_data = 0; b8.out_ready = 1;
      b4.cfg_start = 0; b4.cfg_valid = 0; b4.cfg_data = 0; b4.in_valid = 0; b4.in_data = 0; b4.out_ready = 1;
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;

      @(negedge clk);
      chk("rst_loaded", b8.loaded, 0);
      chk("rst_cfg_ready", b8.cfg_ready, 0);
      chk("rst_cfg_done", b8.cfg_done, 0);
      chk("rst_in_ready", b8.in_ready, 0);
      chk("rst_out_valid", b8.out_valid, 0);
      chk("rst_out_data", b8.out_data, 0);
      chk("rst_out_data4", b4.out_data, 0);
      chk("rst_loaded4", b4.loaded, 0);
      cyc();

      // 1: no table loaded, words and stray config beats are refused
      b8.in_valid = 1'b1; b8.in_data = 8'h04; b8.cfg_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("unl_in_ready", b8.in_ready, 0);
         chk("unl_out_valid", b8.out_valid, 0);
         chk("unl_loaded", b8.loaded, 0);
         chk("unl_cfg_ready", b8.cfg_ready, 0);
         cyc();
      end
      b8.in_valid = 1'b0; b8.cfg_valid = 1'b0;

      // 2: table[v] = v[2], gapped load, then three back-to-back words
      for (int v = 0; v < 256; v++) new_tbl[v] = 3'((v >> 2) & 1);
      load(8, 1'b1, 1'b1, -1);
      b8.in_valid = 1'b1; b8.in_data = 8'h04;
      @(negedge clk); chk("lat_acc", b8.in_ready, 1); cyc();
      b8.in_data = 8'h03;
      @(negedge clk); chk("lat_t1_valid", b8.out_valid, 0); cyc();
      b8.in_data = 8'hFF;
      @(negedge clk); chk("lat_t2_valid", b8.out_valid, 1); chk("lat_t2_data", b8.out_data, 1); cyc();
      b8.in_valid = 1'b0;
      @(negedge clk); chk("lat_t3_valid", b8.out_valid, 1); chk("lat_t3_data", b8.out_data, 0); cyc();
      @(negedge clk); chk("lat_t4_valid", b8.out_valid, 1); chk("lat_t4_data", b8.out_data, 1); cyc();
      @(negedge clk); chk("lat_t5_valid", b8.out_valid, 0); cyc();

      // 3: backpressure for 5 cycles while sending 04, 00, 04
      b8.out_ready = 1'b0; b8.in_valid = 1'b1; b8.in_data = 8'h04;
      @(negedge clk); chk("bp_acc1", b8.in_ready, 1); cyc();
      b8.in_data = 8'h00;
      @(negedge clk); chk("bp_acc2", b8.in_ready, 1); cyc();
      b8.in_data = 8'h04;
      repeat (3) begin
         @(negedge clk);
         chk("bp_stall_ready", b8.in_ready, 0);
         chk("bp_stall_data", b8.out_data, 1);
         cyc();
      end
      b8.out_ready = 1'b1;
      @(negedge clk); chk("bp_rel_ready", b8.in_ready, 1); chk("bp_rel_data0", b8.out_data, 1); cyc();
      b8.in_valid = 1'b0;
      @(negedge clk); chk("bp_rel_valid1", b8.out_valid, 1); chk("bp_rel_data1", b8.out_data, 0); cyc();
      @(negedge clk); chk("bp_rel_valid2", b8.out_valid, 1); chk("bp_rel_data2", b8.out_data, 1); cyc();
      @(negedge clk); chk("bp_rel_empty", b8.out_valid, 0); cyc();

      // 4: reload with table[v] = ~v[2] while two words are in flight
      b8.out_ready = 1'b0;
      send(8, 8'h04);
      send(8, 8'hFF);
      b8.in_valid = 1'b0;
      b8.cfg_start = 1'b1;
      cyc();
      b8.cfg_start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("drain_in_ready", b8.in_ready, 0);
         chk("drain_cfg_ready", b8.cfg_ready, 0);
         chk("drain_out_data", b8.out_data, 1);
         cyc();
      end
      b8.out_ready = 1'b1;
      for (int v = 0; v < 256; v++) new_tbl[v] = 3'(~(v >> 2) & 1);
      load(8, 1'b0, 1'b0, -1);
      send(8, 8'h04);
      b8.in_valid = 1'b0;
      expect_out(8, "reload_new_04", 3'd0);

      // 5: reset at beat 100, then a full random load swept over every address
      for (int v = 0; v < 256; v++) new_tbl[v] = 3'($urandom_range(0, 1));
      load(8, 1'b1, 1'b0, 100);
      for (int v = 0; v < 256; v++) new_tbl[v] = 3'($urandom_range(0, 1));
      load(8, 1'b1, 1'b0, -1);
      sweep(8);

      // 6: 4-bit in / 3-bit out instance, table[v] = v % 7
      for (int v = 0; v < 16; v++) new_tbl[v] = 3'(v % 7);
      load(4, 1'b1, 1'b1, -1);
      send(4, 8'd13);
      b4.in_valid = 1'b0;
      expect_out(4, "n4_13", 3'd6);
      sweep(4);

      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
